box_drawer: RTL
===============

# box_drawer

Parametrised rectangle rasteriser that supersedes the single-pixel box plotter. On a start request it latches a box origin and colour, then walks every pixel of a BOX_W × BOX_H rectangle, emitting one pixel per clock with a plot strobe for the VGA adapter. It clips pixels outside the screen, has an erase mode that paints the background colour, and reports completion to the game control FSM with busy/done.

## Interface

Parameters:
- X_W, 8, width of x coordinate
- Y_W, 7, width of y coordinate
- COLOUR_W, 3, colour width
- BOX_W, 4, box width in pixels (1..2^X_W)
- BOX_H, 4, box height in pixels (1..2^Y_W)
- SCREEN_W, 160, visible columns; x ≥ SCREEN_W is clipped
- SCREEN_H, 120, visible rows; y ≥ SCREEN_H is clipped
- BG_COLOUR, 0, colour used in erase mode

Ports:
- clk  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-high; forces IDLE and clears all outputs
- start  in  1  request to draw; sampled only in IDLE
- erase  in  1  sampled with start; 1 = paint BG_COLOUR instead of colour
- box_x  in  X_W  origin column (left edge), sampled with start
- box_y  in  Y_W  origin row (top edge), sampled with start
- colour  in  COLOUR_W  fill colour, sampled with start
- x  out  X_W  pixel column
- y  out  Y_W  pixel row
- colour_out  out  COLOUR_W  pixel colour
- plot  out  1  pixel write strobe
- busy  out  1  high while rasterising
- done  out  1  one-cycle completion pulse

## Operation

- States: IDLE, DRAW, DONE.
- IDLE: start=1 latches box_x, box_y and the effective colour (BG_COLOUR if erase=1, else colour); column counter cx and row counter cy clear to 0; next state DRAW. start=0 keeps IDLE.
- DRAW: each cycle presents pixel (box_x+cx, box_y+cy) in raster order, cx fastest. When cx = BOX_W-1, cx wraps to 0 and cy increments. When cx = BOX_W-1 and cy = BOX_H-1, next state DONE.
- DONE: done=1 for exactly one cycle, then IDLE.
- Address arithmetic: sums are formed at X_W+1 / Y_W+1 bits. A pixel is clipped when the widened x sum ≥ SCREEN_W or the widened y sum ≥ SCREEN_H. A clipped pixel still consumes its cycle with plot=0. x/y outputs are the low X_W/Y_W bits of the sums.
- start and input changes in DRAW or DONE are ignored. The latched values are held for the whole box.
- Reset at any time, including mid-box: state goes to IDLE and every output goes to 0 asynchronously. The next start begins a fresh box from cx=cy=0.

## Timing

- Reset values: x=0, y=0, colour_out=0, plot=0, busy=0, done=0.
- All outputs are registered.
- With N = BOX_W·BOX_H and start sampled high at edge k:
  - Pixel i (0..N-1) appears on outputs after edge k+1+i, with plot=1 unless clipped.
  - busy=1 after edges k+1 .. k+N.
  - done=1 after edge k+N+1, with busy=0 and plot=0.
- Outside DRAW, plot=0. x, y and colour_out hold their last values.
- Minimum start-to-start period is N+2 cycles. A start held high continuously re-triggers on the first IDLE cycle after done.

## Test plan

- Basic draw (4×4 box, start with box_x=2, box_y=10, colour=3'b100) -> 16 consecutive plot=1 cycles; the first pixel is (2,10) and the last is (5,13); colour_out=4 throughout; done pulses once, 17 edges after the start edge.
- Clipping (box_x=158, box_y=118) -> still 16 DRAW cycles; plot=1 only for (158,118), (159,118), (158,119) and (159,119); x wraps with no carry effects on y; done occurs on time.
- Erase (erase=1, colour=3'b111, BG_COLOUR=0) -> every plotted pixel has colour_out=0; coordinates are identical to a normal draw.
- Ignored start: pulse start with a new box_x=50 at the 5th DRAW cycle -> the current box completes unchanged with x still based on the original origin; no second box is drawn unless start is high in IDLE.
- Reset mid-draw: assert reset at the 7th pixel -> plot, busy and done go to 0 immediately; a subsequent start draws a full 16 pixels from (origin+0, origin+0).
- Parameter sweep (BOX_W=1, BOX_H=1 and BOX_W=8, BOX_H=3) -> 1 and 24 plot cycles respectively; the last pixel is at the origin and at origin+(7,2) respectively; timing is N+1 edges to done.

Source files
------------

// File: rtl/box_drawer.sv
// box_drawer: rectangle rasteriser for the VGA adapter.
// On start (in IDLE) it latches the origin and effective colour, then emits one
// pixel per clock in raster order (column fastest) over a BOX_W x BOX_H box.
// Pixels falling off the visible screen are still walked but not plotted.
//
// Ports:
//   clk, reset          clock, asynchronous active-high reset
//   start, erase        draw request; erase selects BG_COLOUR as the fill
//   box_x, box_y        box origin (top-left), sampled with start
//   colour              fill colour, sampled with start
//   x, y, colour_out    registered pixel address and colour
//   plot                registered pixel write strobe
//   busy, done          rasterising flag and one-cycle completion pulse
module box_drawer #(
    parameter int unsigned X_W       = 8,
    parameter int unsigned Y_W       = 7,
    parameter int unsigned COLOUR_W  = 3,
    parameter int unsigned BOX_W     = 4,
    parameter int unsigned BOX_H     = 4,
    parameter int unsigned SCREEN_W  = 160,
    parameter int unsigned SCREEN_H  = 120,
    parameter int unsigned BG_COLOUR = 0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic                erase,
    input  logic [X_W-1:0]      box_x,
    input  logic [Y_W-1:0]      box_y,
    input  logic [COLOUR_W-1:0] colour,
    output logic [X_W-1:0]      x,
    output logic [Y_W-1:0]      y,
    output logic [COLOUR_W-1:0] colour_out,
    output logic                plot,
    output logic                busy,
    output logic                done
);

    localparam int unsigned XS_W = X_W + 1;
    localparam int unsigned YS_W = Y_W + 1;

    localparam logic [X_W-1:0]      CX_LAST = X_W'(BOX_W - 1);
    localparam logic [Y_W-1:0]      CY_LAST = Y_W'(BOX_H - 1);
    localparam logic [XS_W-1:0]     X_LIM   = XS_W'(SCREEN_W);
    localparam logic [YS_W-1:0]     Y_LIM   = YS_W'(SCREEN_H);
    localparam logic [COLOUR_W-1:0] BG      = COLOUR_W'(BG_COLOUR);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DRAW,
        S_DONE
    } state_t;

    state_t state, state_nx;

    logic [X_W-1:0]      org_x, org_x_nx;
    logic [Y_W-1:0]      org_y, org_y_nx;
    logic [COLOUR_W-1:0] col_q, col_nx;
    logic [X_W-1:0]      cx, cx_nx;
    logic [Y_W-1:0]      cy, cy_nx;

    logic [X_W-1:0]      x_nx;
    logic [Y_W-1:0]      y_nx;
    logic [COLOUR_W-1:0] colour_out_nx;
    logic                plot_nx, busy_nx, done_nx;

    // Widened sums keep the carry so off-screen pixels are detected, not wrapped.
    logic [XS_W-1:0] x_sum;
    logic [YS_W-1:0] y_sum;
    logic            clipped;

    assign x_sum   = {1'b0, org_x} + {1'b0, cx};
    assign y_sum   = {1'b0, org_y} + {1'b0, cy};
    assign clipped = (x_sum >= X_LIM) || (y_sum >= Y_LIM);

    // State, latched request and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            org_x      <= '0;
            org_y      <= '0;
            col_q      <= '0;
            cx         <= '0;
            cy         <= '0;
            x          <= '0;
            y          <= '0;
            colour_out <= '0;
            plot       <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            state      <= state_nx;
            org_x      <= org_x_nx;
            org_y      <= org_y_nx;
            col_q      <= col_nx;
            cx         <= cx_nx;
            cy         <= cy_nx;
            x          <= x_nx;
            y          <= y_nx;
            colour_out <= colour_out_nx;
            plot       <= plot_nx;
            busy       <= busy_nx;
            done       <= done_nx;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_nx      = state;
        org_x_nx      = org_x;
        org_y_nx      = org_y;
        col_nx        = col_q;
        cx_nx         = cx;
        cy_nx         = cy;
        x_nx          = x;
        y_nx          = y;
        colour_out_nx = colour_out;
        plot_nx       = 1'b0;
        busy_nx       = 1'b0;
        done_nx       = 1'b0;

        unique case (state)
            S_IDLE: begin
                if (start) begin
                    org_x_nx = box_x;
                    org_y_nx = box_y;
                    col_nx   = erase ? BG : colour;
                    cx_nx    = '0;
                    cy_nx    = '0;
                    state_nx = S_DRAW;
                end
            end

            S_DRAW: begin
                x_nx          = x_sum[X_W-1:0];
                y_nx          = y_sum[Y_W-1:0];
                colour_out_nx = col_q;
                plot_nx       = !clipped;
                busy_nx       = 1'b1;
                if (cx == CX_LAST) begin
                    cx_nx = '0;
                    if (cy == CY_LAST) begin
                        state_nx = S_DONE;
                    end else begin
                        cy_nx = cy + Y_W'(1);
                    end
                end else begin
                    cx_nx = cx + X_W'(1);
                end
            end

            S_DONE: begin
                done_nx  = 1'b1;
                state_nx = S_IDLE;
            end

            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

endmodule
